// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchroniser, 2-of-3 voted bits, 5..9 data bits, parity, 1/2 stop, break detect.
// A frame completes at tick OVS/2+1 of its last stop bit; the word is registered one clock later into a single-word holding register.
module uart_rx_ovs #(
  parameter int OVS    = 16,
  parameter int DIV_W  = 16,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_divisor,
  input  logic              uart_rx,
  input  logic [3:0]        bits_cfg,
  input  logic [1:0]        parity_cfg,
  input  logic [1:0]        stop_cfg,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_byte,
  output logic              rx_valid,
  output logic              parity_error,
  output logic              frame_error,
  output logic              overrun,
  output logic              break_det,
  output logic              busy
);
  localparam int TW = $clog2(OVS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_BREAK  = 3'd6;

  localparam logic [TW-1:0] TK_LO  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TK_MID = TW'(OVS / 2);
  localparam logic [TW-1:0] TK_HI  = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] TK_END = TW'(OVS - 1);

  logic [1:0]        sync_q;
  logic              prev_q;
  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, div_shr, t_last;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [1:0]        vote_q, vote_d;
  logic [3:0]        bitn_q, bitn_d, nbits_q, nbits_d;
  logic [1:0]        pcfg_q, pcfg_d;
  logic              stop2_q, stop2_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              rx_s, fall, tick, maj, at_hi, at_end;
  logic              done, brk_frame, brk, exp_par, pe_new, fe_new, load, drop;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, pe_q, fe_q, ovr_q, brk_q;

  assign rx_s    = sync_q[1];
  assign fall    = prev_q & ~rx_s;
  assign div_shr = baud_divisor >> TW;
  assign t_last  = (div_shr == '0) ? '0 : div_shr - DIV_W'(1);
  assign tick    = (state_q != S_IDLE) && (div_q == '0);
  assign at_hi   = tick && (tcnt_q == TK_HI);
  assign at_end  = tick && (tcnt_q == TK_END);
  assign maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  // Unused data bits are held at 0, so the XOR over the whole register is the XOR of the frame's data bits.
  assign exp_par   = (pcfg_q == 2'b01) ? ^shift_q : (pcfg_q == 2'b10) ? ~^shift_q : 1'b1;
  assign pe_new    = (pcfg_q != 2'b00) && (par_q != exp_par);
  assign fe_new    = ~maj;
  assign brk_frame = ~maj && (shift_q == '0) && ~par_q;
  assign brk       = done && brk_frame;
  assign load      = done && !brk_frame && (!valid_q || rx_ready);
  assign drop      = done && !brk_frame && valid_q && !rx_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bitn_d  = bitn_q;
    nbits_d = nbits_q;
    pcfg_d  = pcfg_q;
    stop2_d = stop2_q;
    vote_d  = vote_q;
    done    = 1'b0;
    div_d   = (state_q == S_IDLE || div_q == t_last) ? '0 : div_q + DIV_W'(1);
    tcnt_d  = (state_q == S_IDLE) ? '0 : (tick ? tcnt_q + TW'(1) : tcnt_q);
    if (tick && tcnt_q == TK_LO)  vote_d[0] = rx_s;
    if (tick && tcnt_q == TK_MID) vote_d[1] = rx_s;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        shift_d = '0;
        par_d   = 1'b0;
        bitn_d  = 4'd0;
        nbits_d = (bits_cfg >= 4'd5 && bits_cfg <= 4'd9) ? bits_cfg : 4'd8;
        pcfg_d  = parity_cfg;
        stop2_d = (stop_cfg == 2'd2);
      end
      S_START: begin
        if (at_hi && maj) state_d = S_IDLE;
        else if (at_end)  state_d = S_DATA;
      end
      S_DATA: begin
        if (at_hi) shift_d = shift_q | (DATA_W'(maj) << bitn_q);
        if (at_end) begin
          bitn_d = bitn_q + 4'd1;
          if (bitn_q == nbits_q - 4'd1) state_d = (pcfg_q == 2'b00) ? S_STOP1 : S_PARITY;
        end
      end
      S_PARITY: begin
        if (at_hi)  par_d   = maj;
        if (at_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (at_hi && (!maj || !stop2_q)) done = 1'b1;
        else if (at_end)                 state_d = S_STOP2;
      end
      S_STOP2: if (at_hi) done = 1'b1;
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (done) state_d = brk_frame ? S_BREAK : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      vote_q  <= 2'b00;
      bitn_q  <= 4'd0;
      nbits_q <= 4'd8;
      pcfg_q  <= 2'b00;
      stop2_q <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      vote_q  <= vote_d;
      bitn_q  <= bitn_d;
      nbits_q <= nbits_d;
      pcfg_q  <= pcfg_d;
      stop2_q <= stop2_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      brk_q   <= brk;
      if (load) begin
        data_q  <= shift_q;
        pe_q    <= pe_new;
        fe_q    <= fe_new;
        valid_q <= 1'b1;
      end else if (rx_ready) begin
        valid_q <= 1'b0;
      end
      if (drop)         ovr_q <= 1'b1;
      else if (err_clr) ovr_q <= 1'b0;
    end
  end

  assign data_byte    = data_q;
  assign rx_valid     = valid_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;
  assign break_det    = brk_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomized and directed frames against a frame-level reference model of the oversampling UART receiver.
module tb_uart_rx_ovs;
  localparam int OVS = 16, DIV_W = 16, DATA_W = 9;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [DIV_W-1:0]  baud_divisor;
  logic              uart_rx, rx_ready, err_clr;
  logic [3:0]        bits_cfg;
  logic [1:0]        parity_cfg, stop_cfg;
  logic [DATA_W-1:0] data_byte;
  logic              rx_valid, parity_error, frame_error, overrun, break_det, busy;

  uart_rx_ovs #(.OVS(OVS), .DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .baud_divisor(baud_divisor), .uart_rx(uart_rx),
    .bits_cfg(bits_cfg), .parity_cfg(parity_cfg), .stop_cfg(stop_cfg),
    .rx_ready(rx_ready), .err_clr(err_clr), .data_byte(data_byte), .rx_valid(rx_valid),
    .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, edge_cyc = 0, brk_cnt = 0, bit_clks = 160;
  logic vld_prev = 1'b0;
  logic [DATA_W-1:0] q_dat[$];
  bit q_pe[$], q_fe[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: one entry per rising edge of rx_valid, plus a break pulse count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !vld_prev) begin
        q_dat.push_back(data_byte);
        q_pe.push_back(parity_error);
        q_fe.push_back(frame_error);
        q_cyc.push_back(cyc);
      end
      if (break_det) brk_cnt++;
    end
    vld_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    q_dat.delete(); q_pe.delete(); q_fe.delete(); q_cyc.delete();
  endtask

  // Frame-level model: what the receiver should report for one transmitted frame.
  function automatic void model(input int word, input int bcfg, input int par, input bit flip,
                                input int badstop, output int nb, output bit pbit, output int ew,
                                output bit epe, output bit efe, output bit ebrk);
    bit ones;
    nb   = (bcfg >= 5 && bcfg <= 9) ? bcfg : 8;
    ew   = word & ((1 << nb) - 1);
    ones = bit'($countones(ew) & 1);
    pbit = ((par == 1) ? ones : (par == 2) ? !ones : 1'b1) ^ flip;
    epe  = (par != 0) && flip;
    efe  = (badstop != 0);
    ebrk = efe && (ew == 0) && (par == 0 || pbit == 1'b0);
  endfunction

  task automatic send_frame(input int word, input int nb, input bit has_par, input bit pbit,
                            input bit two_stop, input int badstop, input bit noise, input bit scramble);
    bit bits[$];
    bit v;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(bit'((word >> i) & 1));
    if (has_par) bits.push_back(pbit);
    bits.push_back(badstop == 1 ? 1'b0 : 1'b1);
    if (two_stop) bits.push_back(badstop == 2 ? 1'b0 : 1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < bit_clks; c++) begin
        v = bits[b];
        // One tick of inverted line centred on the mid-bit vote sample
        if (noise && b >= 1 && b <= nb && c >= 76 && c < 86) v = !v;
        uart_rx = v;
        if (b == 0 && c == 0) edge_cyc = cyc;
        if (scramble && b == 1 && c == 0) begin
          bits_cfg = 4'($urandom); parity_cfg = 2'($urandom); stop_cfg = 2'($urandom);
        end
        step(1);
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int word, input int bcfg, input int par,
                           input int stopc, input bit flip, input int badstop, input bit noise,
                           input bit scramble, output int lat);
    int nb, ew, brk0;
    bit pbit, epe, efe, ebrk;
    model(word, bcfg, par, flip, badstop, nb, pbit, ew, epe, efe, ebrk);
    bits_cfg = 4'(bcfg); parity_cfg = 2'(par); stop_cfg = 2'(stopc);
    brk0 = brk_cnt;
    clear_q();
    send_frame(word, nb, par != 0, pbit, stopc == 2, badstop, noise, scramble);
    step(2 * bit_clks + 8);
    lat = -1;
    if (ebrk) begin
      chk({tag, "_brk"}, brk_cnt - brk0, 1);
      chk({tag, "_nodat"}, q_dat.size(), 0);
    end else begin
      chk({tag, "_brk"}, brk_cnt - brk0, 0);
      chk({tag, "_cnt"}, q_dat.size(), 1);
      if (q_dat.size() == 1) begin
        chk({tag, "_dat"}, q_dat[0], ew);
        chk({tag, "_pe"}, q_pe[0], epe);
        chk({tag, "_fe"}, q_fe[0], efe);
        lat = q_cyc[0] - edge_cyc;
      end
    end
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
    clear_q();
  endtask

  task automatic glitch(input string tag, input int low_clks);
    clear_q();
    uart_rx = 1'b0;
    step(6);
    chk({tag, "_busy_hi"}, busy, 1);
    step(low_clks - 6);
    uart_rx = 1'b1;
    step(2 * bit_clks);
    chk({tag, "_nodat"}, q_dat.size(), 0);
    chk({tag, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    int lat, brk0, w, bc, pr, sc, bs, dsel;
    bit fl;
    baud_divisor = 16'(bit_clks);
    uart_rx = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
    bits_cfg = 4'd8; parity_cfg = 2'd0; stop_cfg = 2'd1;

    // Reset holds everything at 0 even with the line driven low
    step(2);
    uart_rx = 1'b0;
    step(3);
    chk("rst_outs", {data_byte, rx_valid, parity_error, frame_error, overrun, break_det}, 0);
    chk("rst_busy", busy, 0);
    uart_rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(4);
    chk("post_rst_busy", busy, 0);

    // 8N1 0xA5 with completion latency window
    run_frame("a5", 'hA5, 8, 0, 1, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("a5_lat", (lat >= 19 * bit_clks / 2 && lat <= 19 * bit_clks / 2 + bit_clks / OVS + 8), 1);

    // 9E2 with good and flipped parity
    run_frame("9e2_ok", 'h1FF, 9, 1, 2, 1'b0, 0, 1'b0, 1'b0, lat);
    run_frame("9e2_bad", 'h1FF, 9, 1, 2, 1'b1, 0, 1'b0, 1'b0, lat);

    // False starts
    glitch("glitch1", bit_clks / OVS);
    glitch("glitch6", 6 * bit_clks / OVS);

    // Mid-bit noise rejected by the vote
    run_frame("noise3c", 'h3C, 8, 0, 1, 1'b0, 0, 1'b1, 1'b0, lat);

    // Overrun: second word dropped while the first is unconsumed
    rx_ready = 1'b0;
    run_frame("ovr1", 'h55, 8, 0, 1, 1'b0, 0, 1'b0, 1'b0, lat);
    send_frame('h2A, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(2 * bit_clks);
    chk("ovr_rise_cnt", q_dat.size(), 0);
    chk("ovr_vld", rx_valid, 1);
    chk("ovr_held", data_byte, 'h55);
    chk("ovr_flag", overrun, 1);
    err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
    chk("ovr_clr", overrun, 0);
    chk("ovr_vld_kept", rx_valid, 1);
    rx_ready = 1'b1; step(1);
    chk("ovr_consumed", rx_valid, 0);
    clear_q();

    // Break: 12 bit times of low line
    brk0 = brk_cnt;
    uart_rx = 1'b0;
    step(12 * bit_clks);
    chk("brk_busy", busy, 1);
    chk("brk_pulse", brk_cnt - brk0, 1);
    uart_rx = 1'b1;
    step(10);
    chk("brk_idle", busy, 0);
    chk("brk_nodat", q_dat.size(), 0);

    // Reset during data bits aborts the frame
    brk0 = brk_cnt;
    uart_rx = 1'b0; step(bit_clks);
    uart_rx = 1'b1; step(2 * bit_clks);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step(2);
    chk("mid_rst_outs", {data_byte, rx_valid, parity_error, frame_error, overrun, break_det, busy}, 0);
    rst_n = 1'b1;
    step(4 * bit_clks);
    chk("mid_nodat", q_dat.size(), 0);
    chk("mid_nobrk", brk_cnt - brk0, 0);
    chk("mid_idle", busy, 0);
    run_frame("mid_recover", 'h96, 8, 0, 1, 1'b0, 0, 1'b0, 1'b0, lat);

    // Random frames with config scrambled after the start bit
    for (int k = 0; k < 14; k++) begin
      dsel = $urandom_range(0, 2);
      bit_clks = (dsel == 0) ? 64 : (dsel == 1) ? 96 : 160;
      baud_divisor = 16'(bit_clks);
      w  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 511);
      bc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(5, 9);
      pr = $urandom_range(0, 3);
      sc = $urandom_range(0, 3);
      fl = (pr != 0) && ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0) ? ((sc == 2) ? $urandom_range(1, 2) : 1) : 0;
      run_frame($sformatf("rnd%0d", k), w, bc, pr, sc, fl, bs, 1'b0, 1'b1, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
